// File: rtl/encoder_8x3_seq_pkg.sv
// Shared constants and types for the sequential 8-to-3 encoder.
// Scan order is selected by ENC_MSB_FIRST_EN (see ffs_8).
package enc_pkg;

  localparam int unsigned CODE_W = 3;
  localparam int unsigned LINES  = 1 << CODE_W;

  typedef enum logic [0:0] {
    IDLE,
    BUSY
  } enc_state_t;

  localparam logic [CODE_W-1:0] CODE_NONE = '0;

  // One-hot mask selecting line idx.
  function automatic logic [LINES-1:0] line_mask(input logic [CODE_W-1:0] idx);
    return LINES'(1) << idx;
  endfunction

endpackage

// File: rtl/encoder_8x3_ffs.sv
// Combinational find-first-set over an 8-bit vector, plus an exactly-one-bit flag.
// ENC_MSB_FIRST_EN: search from the top by bit-reversing vec and inverting the index.
module ffs_8
  import enc_pkg::*;
(
  input  logic [LINES-1:0]  vec,
  output logic [CODE_W-1:0] idx,
  output logic              one_hot
);

  logic [LINES-1:0]  w_scan;
  logic [CODE_W-1:0] w_low;

  always_comb begin
    w_scan = '0;
`ifdef ENC_MSB_FIRST_EN
    for (int i = 0; i < int'(LINES); i++) begin
      w_scan[i] = vec[int'(LINES)-1-i];
    end
`else
    w_scan = vec;
`endif
  end

  // Walk downwards so the last hit is the lowest set bit.
  always_comb begin
    w_low = CODE_NONE;
    for (int i = int'(LINES) - 1; i >= 0; i--) begin
      if (w_scan[i]) begin
        w_low = CODE_W'(i);
      end
    end
  end

`ifdef ENC_MSB_FIRST_EN
  assign idx = ~w_low;
`else
  assign idx = w_low;
`endif

  assign one_hot = (vec != '0) && ((vec & (vec - LINES'(1))) == '0);

endmodule

// File: rtl/encoder_8x3_seq.sv
// Sequential 8-to-3 encoder: captures a line vector, then emits one code per set line.
// Scan order follows ENC_MSB_FIRST_EN (default lowest index first).
module encoder_8x3_seq
  import enc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LINES-1:0]  S,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              out_last,
  output logic              zero_err
);

  enc_state_t       r_state;
  enc_state_t       w_state_next;
  logic [LINES-1:0] r_pending;
  logic [LINES-1:0] w_pending_next;
  logic             r_zero_err;
  logic             w_zero_err_next;

  logic [CODE_W-1:0] w_idx;
  logic              w_one_hot;
  logic              w_busy;

  ffs_8 u_ffs (
    .vec     (r_pending),
    .idx     (w_idx),
    .one_hot (w_one_hot)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_pending  <= '0;
      r_zero_err <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pending  <= w_pending_next;
      r_zero_err <= w_zero_err_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_pending_next  = r_pending;
    w_zero_err_next = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          if (S != '0) begin
            w_pending_next = S;
            w_state_next   = BUSY;
          end else begin
            w_zero_err_next = 1'b1;
          end
        end
      end
      BUSY: begin
        if (out_ready) begin
          w_pending_next = r_pending & ~line_mask(w_idx);
          if (w_one_hot) begin
            w_state_next = IDLE;
          end
        end
      end
      default: begin
        w_state_next   = IDLE;
        w_pending_next = '0;
      end
    endcase
  end

  assign w_busy    = (r_state == BUSY);
  assign in_ready  = (r_state == IDLE);
  assign out_valid = w_busy;
  // Outputs are forced to known values outside BUSY.
  assign out_code  = w_busy ? w_idx : CODE_NONE;
  assign out_last  = w_busy & w_one_hot;
  assign zero_err  = r_zero_err;

endmodule

// File: doc/encoder_8x3_seq.md
Name: encoder_8x3_seq

Overview:
- Sequential 8-to-3 encoder; inverse of the team's 3x8 decoder.
- Accepts an 8-bit line vector S on a valid/ready handshake.
- Emits the 3-bit code {z,a,b} of every set line, one code per output handshake, lowest index first.
- Sits upstream of decoder_3x8_gates so that decoder(encoder(S)) reconstructs S one line at a time.

Parameters:
- CODE_W, 3, code width.
- LINES, 8 (= 1<<CODE_W), input vector width; derived, not overridden independently.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  S is presented.
- in_ready  output  1  block can capture S.
- S  input  8  line vector; bit i set means line i is active.
- out_valid  output  1  out_code is valid.
- out_ready  input  1  consumer accepts out_code.
- out_code  output  3  encoded line index {z,a,b}; z is the MSB.
- out_last  output  1  out_code is the final set line of the captured vector.
- zero_err  output  1  one-cycle pulse when an all-zero vector is captured.

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on rst.
- Reset values:
  - state=IDLE, pending=8'h00
  - in_ready=1, out_valid=0, out_code=3'b000, out_last=0, zero_err=0
- States: IDLE, BUSY. in_ready = (state==IDLE); out_valid = (state==BUSY). Both are decoded from registered state.
- IDLE:
  - On in_valid&in_ready with S!=0: pending<=S, go to BUSY.
  - On in_valid&in_ready with S==0: zero_err=1 for the next cycle only; stay in IDLE; no code is emitted.
- BUSY:
  - out_code = index of the lowest set bit of pending (default order).
  - out_last = 1 iff pending has exactly one bit set.
  - On out_ready: clear that bit in pending. If out_last=1, return to IDLE; otherwise stay in BUSY and present the next index in the following cycle.
- Latency: S captured at edge N gives out_valid=1 after edge N. A vector with k set bits needs exactly k output handshakes.
- Throughput: in_ready rises the cycle after the last handshake, so there is one bubble between vectors.
- Stall: while out_valid=1 and out_ready=0, out_code and out_last hold stable. S and in_valid are ignored in BUSY.
- S=8'hFF emits codes 0..7 in order; out_last=1 only with code 7 (default order).
- zero_err and a capture cannot overlap: zero_err is only set from IDLE, and the block stays in IDLE.
- Reset mid-operation: pending clears immediately. out_valid drops asynchronously and the remaining codes are discarded. The first edge after rst deasserts can capture a new vector.
- No X propagation: out_code=3'b000 whenever out_valid=0.

Optional Feature:
- Macro: ENC_MSB_FIRST_EN.
- Defined: BUSY selects the highest set bit of pending, so S=8'h81 emits 7 then 0, and out_last accompanies the lowest set bit.
- Undefined: lowest-first order as above.
- The macro changes only the scan order; handshakes, latency and zero_err are identical with and without it.

Decomposition:
- Package enc_pkg holds:
  - CODE_W, LINES
  - state typedef enc_state_t {IDLE, BUSY}
  - constant CODE_NONE=3'b000
- Sub-module ffs_8: combinational find-first-set. Inputs: vec[7:0]. Outputs: idx[2:0], one_hot (vector has exactly one bit set).
- ENC_MSB_FIRST_EN is implemented inside ffs_8 by bit-reversing vec and inverting idx.

Test Plan:
- Reset, then S=8'h04 with in_valid=1 and out_ready held 1: one code 3'b010 with out_last=1; in_ready returns 1 one cycle later.
- S=8'hA5 with out_ready=1: codes 0,2,5,7 on consecutive cycles; out_last only with 7. With ENC_MSB_FIRST_EN: codes 7,5,2,0, out_last only with 0.
- S=8'h30 with out_ready held 0 for 5 cycles: out_code=3'b100 stays stable. Release out_ready: 3'b100 then 3'b101, out_last=1 on 3'b101.
- S=8'h00 captured: zero_err=1 for exactly one cycle; out_valid stays 0; in_ready stays 1.
- S=8'hFF, assert rst after the third code is accepted: out_valid=0 and pending=0 immediately. After rst drops, S=8'h80 yields a single code 3'b111 with out_last=1.
- Loopback: feed each out_code as {z,a,b} into decoder_3x8_gates and OR the decoder outputs over the burst; the result must equal the captured S for all 256 values of S except 0.
